// File: rtl/round_sequencer_pkg.sv
// Shared types, widths and the code-to-lamp encoding for the Simon Says game controller.
package round_sequencer_pkg;

    localparam int unsigned ROUND_W = 6;
    localparam int unsigned LAMP_W  = 4;
    localparam int unsigned CODE_W  = 2;

    typedef enum logic [2:0] {
        IDLE,
        SHOW_ON,
        SHOW_GAP,
        WAIT_PRESS,
        WAIT_RELEASE,
        CHECK,
        WIN,
        LOSE
    } state_t;

    // One-hot lamp for a segment code; verify_input uses the same mapping.
    function automatic logic [LAMP_W-1:0] code2lamp(input logic [CODE_W-1:0] code);
        return LAMP_W'(1) << code;
    endfunction

endpackage

// File: rtl/round_sequencer_tick_timer.sv
// Free-running cycle counter with synchronous clear; saturates instead of wrapping.
module round_sequencer_tick_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] count_o,
    output logic         done_o
);

    logic [W-1:0] count_q;

    // Count cycles spent in the current phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;
    assign done_o  = (count_q == limit_i);

endmodule

// File: rtl/round_sequencer.sv
// Game-level controller: plays back the sequence, collects presses, tracks rounds and score.
module round_sequencer
    import round_sequencer_pkg::*;
#(
    parameter int unsigned MAX_ROUND     = 33,
    parameter int unsigned SHOW_TICKS    = 25,
    parameter int unsigned GAP_TICKS     = 10,
    parameter int unsigned TIMEOUT_TICKS = 500
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LAMP_W-1:0]  player_input,
    input  logic [CODE_W-1:0]  seg_val,
    input  logic               check_result,
    output logic [ROUND_W-1:0] check_round,
    output logic [LAMP_W-1:0]  press_code,
    output logic [LAMP_W-1:0]  lamp,
    output logic               busy,
    output logic               win,
    output logic               lose,
    output logic [ROUND_W-1:0] score
);

    localparam int unsigned MAX_TICKS =
        (SHOW_TICKS > GAP_TICKS) ?
            ((SHOW_TICKS > TIMEOUT_TICKS) ? SHOW_TICKS : TIMEOUT_TICKS) :
            ((GAP_TICKS  > TIMEOUT_TICKS) ? GAP_TICKS  : TIMEOUT_TICKS);
    localparam int unsigned TIMER_W = $clog2(MAX_TICKS + 1);

    localparam logic [TIMER_W-1:0] SHOW_LIMIT    = TIMER_W'(SHOW_TICKS - 1);
    localparam logic [TIMER_W-1:0] GAP_LIMIT     = TIMER_W'(GAP_TICKS - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LIMIT = TIMER_W'(TIMEOUT_TICKS - 1);
    localparam logic               TIMEOUT_EN    = (TIMEOUT_TICKS != 0);
    localparam logic [ROUND_W-1:0] LAST_ROUND    = ROUND_W'(MAX_ROUND - 1);
    localparam logic [ROUND_W-1:0] SCORE_MAX     = ROUND_W'(MAX_ROUND);

    state_t               state_q, state_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic [ROUND_W-1:0]   check_round_q, check_round_d;
    logic [ROUND_W-1:0]   score_q, score_d;
    logic [LAMP_W-1:0]    press_q, press_d;
    logic [LAMP_W-1:0]    lamp_q, lamp_d;
    logic                 busy_q, busy_d;
    logic                 win_q, win_d;
    logic                 lose_q, lose_d;

    logic                 t_clear;
    logic [TIMER_W-1:0]   t_limit;
    logic [TIMER_W-1:0]   t_count;
    logic                 t_done;
    logic                 timeout_hit;

    // Single timer shared by the show, gap and press-timeout phases; restarts on each state entry.
    round_sequencer_tick_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear_i (t_clear),
        .en_i    (1'b1),
        .limit_i (t_limit),
        .count_o (t_count),
        .done_o  (t_done)
    );

    assign t_clear     = (state_d != state_q);
    assign t_limit     = (state_q == SHOW_GAP) ? GAP_LIMIT : SHOW_LIMIT;
    assign timeout_hit = TIMEOUT_EN && (t_count == TIMEOUT_LIMIT);

    // Next-state, counter and output decode. lamp is registered, so it trails the state by
    // one cycle: seg_val only becomes valid once the new check_round has been presented.
    always_comb begin
        state_d       = state_q;
        round_d       = round_q;
        check_round_d = check_round_q;
        score_d       = score_q;
        press_d       = press_q;
        lamp_d        = '0;

        case (state_q)
            IDLE, WIN, LOSE: begin
                if (start) begin
                    state_d       = SHOW_ON;
                    round_d       = '0;
                    score_d       = '0;
                    check_round_d = '0;
                end
            end
            SHOW_ON: begin
                lamp_d = code2lamp(seg_val);
                if (t_done) begin
                    state_d = SHOW_GAP;
                end
            end
            SHOW_GAP: begin
                if (t_done) begin
                    if (check_round_q < round_q) begin
                        check_round_d = check_round_q + ROUND_W'(1);
                        state_d       = SHOW_ON;
                    end else begin
                        check_round_d = '0;
                        press_d       = '0;
                        state_d       = WAIT_PRESS;
                    end
                end
            end
            WAIT_PRESS: begin
                if (player_input != '0) begin
                    press_d = player_input;
                    state_d = WAIT_RELEASE;
                end else if (timeout_hit) begin
                    state_d = LOSE;
                end
            end
            WAIT_RELEASE: begin
                lamp_d = press_q;
                if (player_input == '0) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!check_result) begin
                    state_d = LOSE;
                end else if (check_round_q < round_q) begin
                    check_round_d = check_round_q + ROUND_W'(1);
                    press_d       = '0;
                    state_d       = WAIT_PRESS;
                end else begin
                    if (score_q != SCORE_MAX) begin
                        score_d = score_q + ROUND_W'(1);
                    end
                    if (round_q == LAST_ROUND) begin
                        state_d = WIN;
                    end else begin
                        round_d       = round_q + ROUND_W'(1);
                        check_round_d = '0;
                        state_d       = SHOW_ON;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE) && (state_d != WIN) && (state_d != LOSE);
        win_d  = (state_d == WIN);
        lose_d = (state_d == LOSE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            round_q       <= '0;
            check_round_q <= '0;
            score_q       <= '0;
            press_q       <= '0;
            lamp_q        <= '0;
            busy_q        <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            round_q       <= round_d;
            check_round_q <= check_round_d;
            score_q       <= score_d;
            press_q       <= press_d;
            lamp_q        <= lamp_d;
            busy_q        <= busy_d;
            win_q         <= win_d;
            lose_q        <= lose_d;
        end
    end

    assign check_round = check_round_q;
    assign press_code  = press_q;
    assign lamp        = lamp_q;
    assign busy        = busy_q;
    assign win         = win_q;
    assign lose        = lose_q;
    assign score       = score_q;

endmodule
